// File: rtl/idp_pkg.sv
// idp_pkg: shared constants and types for the integer data path sequencer.
// Opcodes, ALU codes, FSM state encoding, field positions and control word.
package idp_pkg;

    localparam logic [3:0] OP_MAX_REG = 4'hB;
    localparam logic [3:0] OP_LDI     = 4'hC;
    localparam logic [3:0] OP_ADDI    = 4'hD;
    localparam logic [3:0] OP_NOP     = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [3:0] ALU_NONE   = 4'h0;
    localparam logic [3:0] ALU_PASS_S = 4'h1;
    localparam logic [3:0] ALU_ADD    = 4'h4;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int WA_HI = 11;
    localparam int WA_LO = 9;
    localparam int RA_HI = 8;
    localparam int RA_LO = 6;
    localparam int SA_HI = 5;
    localparam int SA_LO = 3;

    localparam logic [15:0] IR_RESET = 16'hE000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_IMM   = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic        w_en;
        logic [2:0]  w_adr;
        logic [2:0]  r_adr;
        logic [2:0]  s_adr;
        logic        s_sel;
        logic [3:0]  alu_op;
        logic [15:0] ds;
    } ctrl_t;

    function automatic logic [3:0] opcode(input logic [15:0] w);
        return w[OP_HI:OP_LO];
    endfunction

    function automatic logic needs_imm(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/idp_sequencer_if.sv
// idp_sequencer_if: instruction stream valid/ready handshake.
// The source is the master; the sequencer is the slave.
interface idp_sequencer_if;

    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/idp_decode.sv
// idp_decode: combinational map from IR and immediate to the control word.
// Address, ALU_OP and DS follow the registers; W_En and S_Sel only in EXEC.
module idp_decode
    import idp_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] imm,
    input  logic        exec,
    output ctrl_t       ctrl
);

    logic [3:0] op;
    logic       unused_fields;

    assign op            = opcode(ir);
    assign unused_fields = ^ir[2:0];

    // Decode opcode class into ALU operation and S-mux select
    always_comb begin
        ctrl        = '0;
        ctrl.w_en   = exec;
        ctrl.w_adr  = ir[WA_HI:WA_LO];
        ctrl.r_adr  = ir[RA_HI:RA_LO];
        ctrl.s_adr  = ir[SA_HI:SA_LO];
        ctrl.ds     = imm;
        ctrl.alu_op = ALU_NONE;
        unique case (1'b1)
            (op <= OP_MAX_REG): begin
                ctrl.alu_op = op;
            end
            (op == OP_LDI): begin
                ctrl.alu_op = ALU_PASS_S;
                ctrl.s_sel  = exec;
            end
            (op == OP_ADDI): begin
                ctrl.alu_op = ALU_ADD;
                ctrl.s_sel  = exec;
            end
            default: begin
                ctrl.alu_op = ALU_NONE;
            end
        endcase
    end

endmodule

// File: rtl/idp_sequencer.sv
// idp_sequencer: fetch/immediate/execute/halt control FSM for the data path.
// Holds IR, immediate, latched ALU flags and the retired-instruction count.
module idp_sequencer
    import idp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    idp_sequencer_if.slave   bus,
    input  logic             C,
    input  logic             N,
    input  logic             Z,
    output logic             W_En,
    output logic [2:0]       W_Adr,
    output logic [2:0]       R_Adr,
    output logic [2:0]       S_Adr,
    output logic             S_Sel,
    output logic [3:0]       ALU_OP,
    output logic [15:0]      DS,
    output logic             flag_C,
    output logic             flag_N,
    output logic             flag_Z,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;
    logic [15:0] imm;
    logic        rdy;
    logic        ir_ld;
    logic        imm_ld;
    logic        flg_ld;
    logic        cnt_inc;
    logic [3:0]  in_op;
    ctrl_t       ctrl;

    assign in_op = opcode(bus.instr);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_FETCH;
        else       state <= next_state;
    end

    // Next state and register load strobes
    always_comb begin
        next_state = state;
        rdy        = 1'b0;
        ir_ld      = 1'b0;
        imm_ld     = 1'b0;
        flg_ld     = 1'b0;
        cnt_inc    = 1'b0;
        unique case (state)
            ST_FETCH: begin
                rdy = 1'b1;
                if (bus.instr_valid) begin
                    ir_ld = 1'b1;
                    unique case (1'b1)
                        needs_imm(in_op): next_state = ST_IMM;
                        (in_op == OP_NOP): begin
                            next_state = ST_FETCH;
                            cnt_inc    = 1'b1;
                        end
                        (in_op == OP_HALT): begin
                            next_state = ST_HALT;
                            cnt_inc    = 1'b1;
                        end
                        default: next_state = ST_EXEC;
                    endcase
                end
            end
            ST_IMM: begin
                rdy = 1'b1;
                if (bus.instr_valid) begin
                    imm_ld     = 1'b1;
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                flg_ld     = 1'b1;
                cnt_inc    = 1'b1;
                next_state = ST_FETCH;
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

    // Instruction, immediate, flag and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ir          <= IR_RESET;
            imm         <= '0;
            flag_C      <= 1'b0;
            flag_N      <= 1'b0;
            flag_Z      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (ir_ld)  ir  <= bus.instr;
            if (imm_ld) imm <= bus.instr;
            if (flg_ld) begin
                flag_C <= C;
                flag_N <= N;
                flag_Z <= Z;
            end
            if (cnt_inc) instr_count <= instr_count + CNT_W'(1);
        end
    end

    idp_decode u_decode (
        .ir   (ir),
        .imm  (imm),
        .exec (state == ST_EXEC),
        .ctrl (ctrl)
    );

    assign bus.instr_ready = rdy & ~reset;
    assign halted          = (state == ST_HALT);
    assign W_En            = ctrl.w_en;
    assign W_Adr           = ctrl.w_adr;
    assign R_Adr           = ctrl.r_adr;
    assign S_Adr           = ctrl.s_adr;
    assign S_Sel           = ctrl.s_sel;
    assign ALU_OP          = ctrl.alu_op;
    assign DS              = ctrl.ds;

endmodule

// File: doc/idp_sequencer.md
# idp_sequencer

Multi-cycle control sequencer that drives the integer data path's control interface: write enable, register addresses, S-mux select, ALU opcode and immediate data. It accepts 16-bit instruction words over a valid/ready handshake, decodes them, and issues one control word per instruction. It latches the ALU status flags (C, N, Z) returned by the data path. It sits between instruction memory or a testbench stream and the data path.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `instr`, input, 16: instruction or immediate word.
- `instr_valid`, input, 1: `instr` is valid.
- `instr_ready`, output, 1: sequencer accepts `instr` this cycle.
- `C`, `N`, `Z`, input, 1 each: status flags from the data path ALU.
- `W_En`, output, 1: register-file write enable.
- `W_Adr`, `R_Adr`, `S_Adr`, output, 3 each: destination, R-source and S-source register addresses.
- `S_Sel`, output, 1: 0 selects the register S operand; 1 selects `DS`.
- `ALU_OP`, output, 4: ALU operation.
- `DS`, output, 16: immediate data to the S-mux.
- `flag_C`, `flag_N`, `flag_Z`, output, 1 each: latched status flags.
- `halted`, output, 1: a HALT instruction has executed.
- `instr_count`, output, `CNT_W`: count of retired instructions.

## Operation
Instruction format:
- `[15:12]` opcode
- `[11:9]` W_Adr
- `[8:6]` R_Adr
- `[5:3]` S_Adr
- `[2:0]` ignored

Opcodes:
- 0x0–0xB: register ALU op. `ALU_OP` = opcode, `S_Sel`=0.
- 0xC LDI: second word is the immediate. `ALU_OP`=`ALU_PASS_S` (4'h1), `S_Sel`=1.
- 0xD ADDI: second word is the immediate. `ALU_OP`=`ALU_ADD` (4'h4), `S_Sel`=1.
- 0xE NOP: no data-path activity.
- 0xF HALT.

States:
- FETCH:
  - `instr_ready`=1.
  - On `instr_valid`, load `instr` into the instruction register (IR).
  - Next state: IMM for 0xC/0xD; FETCH for NOP (count +1); HALT for 0xF (count +1); otherwise EXEC.
- IMM:
  - `instr_ready`=1.
  - On `instr_valid`, load `instr` into the immediate register, then go to EXEC.
  - Without `instr_valid`, stay in IMM.
- EXEC:
  - `instr_ready`=0.
  - Drive the control word decoded from IR with `W_En`=1 for exactly this cycle.
  - At the closing edge: capture `C`, `N`, `Z` into `flag_*`, increment `instr_count`, go to FETCH.
- HALT:
  - `instr_ready`=0 and `halted`=1 until `reset`.

Rules:
- `W_En` is 1 only in EXEC. In all other states `W_En`=0 and `S_Sel`=0.
- Address, `ALU_OP` and `DS` outputs always reflect IR and the immediate register, so they are stable throughout EXEC.
- `instr_count` wraps from 2^CNT_W−1 to 0.
- Flags update only on EXEC. NOP and HALT leave the flags unchanged.
- A word offered with `instr_valid` while `instr_ready`=0 is not consumed. The source must hold it.

## Timing
- Reset values (registered outputs):
  - state FETCH
  - IR = 0xE000 (NOP)
  - immediate = 0
  - `W_En`=0, `S_Sel`=0
  - all addresses 0
  - `ALU_OP`=0, `DS`=0
  - `flag_*`=0, `halted`=0, `instr_count`=0
- `instr_ready`=0 while `reset` is high. It is 1 on the first cycle after reset.
- Latency:
  - Register op: 2 cycles, handshake then EXEC.
  - Immediate op: 3 cycles minimum.
  - NOP: 1 cycle.
- Back-to-back issue: after EXEC, `instr_ready` rises in the next cycle, giving one instruction every 2 cycles at best.
- Reset asserted during EXEC: the write still happens on that edge because the register file samples `W_En`=1. `flag_*` and `instr_count` are reset, not updated. The next cycle is FETCH.
- Reset asserted during IMM: the pending instruction is discarded.
- HALT is left only by `reset`.

## Structure
- Package `idp_pkg` holds:
  - opcode constants OP_LDI, OP_ADDI, OP_NOP, OP_HALT
  - ALU_PASS_S, ALU_ADD
  - state encoding ST_FETCH, ST_IMM, ST_EXEC, ST_HALT (2 bits)
  - field bit positions
- One sub-module, `idp_decode`: combinational mapping from IR and the immediate to the control word. The FSM and registers stay in `idp_sequencer`.
- Top-level integration pairs `idp_sequencer` with the data path, with flags fed back.

## Test plan
- Register op: after reset, stream 0x4298 (op 4, W=1, R=2, S=3) with valid held. Expect `instr_ready` 1 then 0. EXEC cycle shows `W_En`=1, W_Adr=1, R_Adr=2, S_Adr=3, ALU_OP=4, S_Sel=0. `instr_count`=1.
- LDI: send 0xC600 then 0x1234, with `instr_valid` gapped 3 cycles between the words. Expect a wait in IMM. EXEC shows S_Sel=1, DS=0x1234, ALU_OP=1, W_Adr=3.
- Flags: ADD in EXEC with C=1, N=0, Z=1. Expect `flag_C`=1, `flag_Z`=1 the next cycle. A following NOP leaves them unchanged.
- HALT: send 0xF000 then further valid words. Expect `halted`=1, `instr_ready` held 0, no `W_En`, count +1. After `reset`: everything at reset values and `instr_ready`=1.
- Reset mid-op: assert `reset` during IMM of an ADDI. Expect no EXEC, count 0, FETCH next cycle.
- Wrap: with CNT_W=4, retire 17 NOPs. Expect `instr_count`=1.
